// File: rtl/seven_segment_pkg.sv
// Shared segment-pattern type and glyph constants for the seven_segment slice.
// Bit order is A (bit 6) down to G (bit 0); patterns are active-high (1 = lit).
package seven_segment_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b0000000;
    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_HEX_A = 7'b1110111;
    localparam seg_t SEG_HEX_B = 7'b0011111;
    localparam seg_t SEG_HEX_C = 7'b1001110;
    localparam seg_t SEG_HEX_D = 7'b0111101;
    localparam seg_t SEG_HEX_E = 7'b1001111;
    localparam seg_t SEG_HEX_F = 7'b1000111;

endpackage

// File: rtl/seven_segment_rom.sv
// Combinational BCD/hex to active-high segment decode.
// Define SEVEN_SEGMENT_HEX_EN to show glyphs A-F for 10-15; otherwise they blank.
module seven_segment_rom
    import seven_segment_pkg::*;
(
    input  logic [3:0] value,
    output seg_t       pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (value)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
`ifdef SEVEN_SEGMENT_HEX_EN
            4'd10:   pattern = SEG_HEX_A;
            4'd11:   pattern = SEG_HEX_B;
            4'd12:   pattern = SEG_HEX_C;
            4'd13:   pattern = SEG_HEX_D;
            4'd14:   pattern = SEG_HEX_E;
            4'd15:   pattern = SEG_HEX_F;
`endif
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment.sv
// Registered seven-segment driver: decode {W,X,Y,Z}, apply polarity, register.
// Hex glyphs for 10-15 are enabled by defining SEVEN_SEGMENT_HEX_EN.
module seven_segment
    import seven_segment_pkg::*;
#(
    parameter bit ACTIVE_LOW_SEG = 1'b0
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic W,
    input  logic X,
    input  logic Y,
    input  logic Z,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic E,
    output logic F,
    output logic G
);

    // Polarity is folded in before the register so the outputs come straight off flops.
    localparam seg_t POL_MASK = ACTIVE_LOW_SEG ? '1 : '0;

    seg_t pattern;
    seg_t seg_q;

    seven_segment_rom u_rom (
        .value   ({W, X, Y, Z}),
        .pattern (pattern)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q <= SEG_BLANK ^ POL_MASK;
        end else begin
            seg_q <= pattern ^ POL_MASK;
        end
    end

    assign {A, B, C, D, E, F, G} = seg_q;

endmodule

// File: tb/tb_seven_segment.sv
// Scoreboard bench for seven_segment: both polarities driven from the same stimulus.
// Hex expectations follow SEVEN_SEGMENT_HEX_EN when it is defined for the build.
module tb_seven_segment;

    logic clk = 1'b0;
    logic rst_n;
    logic W, X, Y, Z;
    logic A0, B0, C0, D0, E0, F0, G0;
    logic A1, B1, C1, D1, E1, F1, G1;
    logic [6:0] seg_hi;
    logic [6:0] seg_lo;

    int total = 0;
    int bad   = 0;
    logic [6:0] sb[$];

    always #5 clk = ~clk;

    seven_segment #(.ACTIVE_LOW_SEG(1'b0)) dut_hi (
        .clk(clk), .rst_n(rst_n), .W(W), .X(X), .Y(Y), .Z(Z),
        .A(A0), .B(B0), .C(C0), .D(D0), .E(E0), .F(F0), .G(G0)
    );

    seven_segment #(.ACTIVE_LOW_SEG(1'b1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .W(W), .X(X), .Y(Y), .Z(Z),
        .A(A1), .B(B1), .C(C1), .D(D1), .E(E1), .F(F1), .G(G1)
    );

    assign seg_hi = {A0, B0, C0, D0, E0, F0, G0};
    assign seg_lo = {A1, B1, C1, D1, E1, F1, G1};

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:  return 7'b1111110;
            4'd1:  return 7'b0110000;
            4'd2:  return 7'b1101101;
            4'd3:  return 7'b1111001;
            4'd4:  return 7'b0110011;
            4'd5:  return 7'b1011011;
            4'd6:  return 7'b1011111;
            4'd7:  return 7'b1110000;
            4'd8:  return 7'b1111111;
            4'd9:  return 7'b1111011;
`ifdef SEVEN_SEGMENT_HEX_EN
            4'd10: return 7'b1110111;
            4'd11: return 7'b0011111;
            4'd12: return 7'b1001110;
            4'd13: return 7'b0111101;
            4'd14: return 7'b1001111;
            4'd15: return 7'b1000111;
`endif
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%b want=%b at t=%0t", name, got, want, $time);
        end
    endtask

    // Drive at negedge; the response is due one posedge later.
    task automatic step(input logic r, input logic [3:0] v);
        @(negedge clk);
        rst_n = r;
        {W, X, Y, Z} = v;
        sb.push_back(r ? glyph(v) : 7'b0000000);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            logic [6:0] exp;
            exp = sb.pop_front();
            check("seg_active_high", seg_hi, exp);
            check("seg_active_low", seg_lo, ~exp);
        end
    end

    initial begin
        rst_n = 1'b0;
        {W, X, Y, Z} = 4'b1000;

        // reset held with input 8, then release
        step(1'b0, 4'd8);
        step(1'b0, 4'd8);
        step(1'b1, 4'd8);

        for (int v = 0; v < 16; v++) step(1'b1, 4'(v));

        // spot checks of individual digits against literal patterns
        @(posedge clk); #2;
        check("hex_f_or_blank", seg_hi,
`ifdef SEVEN_SEGMENT_HEX_EN
              7'b1000111
`else
              7'b0000000
`endif
        );

        step(1'b1, 4'd0);
        step(1'b1, 4'd8);
        // input changes between edges must not reach the outputs
        @(posedge clk); #2;
        {W, X, Y, Z} = 4'd1;
        #1;
        check("hold_mid_cycle_hi", seg_hi, 7'b1111111);
        check("hold_mid_cycle_lo", seg_lo, 7'b0000000);
        step(1'b1, 4'd1);
        step(1'b1, 4'd8);

        // reset mid-sequence blanks at once and ignores inputs
        step(1'b0, 4'd8);
        step(1'b0, 4'd3);
        step(1'b0, 4'd15);
        step(1'b1, 4'd3);
        step(1'b1, 4'd7);
        step(1'b1, 4'd11);
        step(1'b1, 4'd9);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_segment.md
SEVEN_SEGMENT -- requirements
Module: seven_segment

Interface
REQ-001 Parameter ACTIVE_LOW_SEG, default 0, meaning: 0 = segment lit by driving 1 (common-cathode); 1 = all seven segment outputs inverted (common-anode).
REQ-002 Port clk  input  1  single rising-edge clock; all state changes on posedge clk.
REQ-003 Port rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port W  input  1  BCD digit bit 3 (MSB).
REQ-005 Port X  input  1  BCD digit bit 2.
REQ-006 Port Y  input  1  BCD digit bit 1.
REQ-007 Port Z  input  1  BCD digit bit 0 (LSB).
REQ-008 Ports A, B, C, D, E, F, G  output  1 each  segment drives: A top, B upper-right, C lower-right, D bottom, E lower-left, F upper-left, G middle.
REQ-009 Port order after clk, rst_n SHALL be W, X, Y, Z, A, B, C, D, E, F, G.

Function
REQ-010 Digit value = {W,X,Y,Z}, unsigned 0-15.
REQ-011 Outputs SHALL be registered; the pattern for the digit sampled at posedge N SHALL appear after posedge N (1-cycle latency), with no combinational path from inputs to outputs.
REQ-012 Lit segments (ACTIVE_LOW_SEG=0): 0=ABCDEF, 1=BC, 2=ABDEG, 3=ABCDG, 4=BCFG, 5=ACDFG, 6=ACDEFG, 7=ABC, 8=ABCDEFG, 9=ABCDFG; all unlisted segments off.
REQ-013 Values 10-15 without SEVEN_SEGMENT_HEX_EN SHALL blank the display (all segments off).
REQ-014 Outputs SHALL hold their value while inputs are stable; an input change SHALL take effect at the next posedge only.
REQ-015 ACTIVE_LOW_SEG=1 SHALL invert every segment output, including the reset and blank values.

Reset
REQ-016 When rst_n=0 at a posedge, all segments SHALL go off (0 if ACTIVE_LOW_SEG=0, 1 if ACTIVE_LOW_SEG=1) at that edge, regardless of inputs.
REQ-017 The first posedge with rst_n=1 SHALL load the decode of the current inputs; reset asserted mid-sequence SHALL blank the display at the next edge, with no residual state.

Configuration
REQ-018 Macro SEVEN_SEGMENT_HEX_EN defined: values 10-15 SHALL display hex glyphs A=ABCEFG, b=CDEFG, C=ADEF, d=BCDEG, E=ADEFG, F=AEFG.
REQ-019 Macro SEVEN_SEGMENT_HEX_EN undefined: values 10-15 SHALL blank per REQ-013; decoding of values 0-9 SHALL be identical in both builds.

Structure
REQ-020 Package seven_segment_pkg SHALL hold the 7-bit segment-pattern type (bit order A..G) and named constants for the glyphs 0-9, A-F, and BLANK.
REQ-021 A purely combinational sub-module seven_segment_rom (4-bit value in, 7-bit active-high pattern out, honouring SEVEN_SEGMENT_HEX_EN) SHALL perform the decode.
REQ-022 The top level SHALL contain only the output register, the reset logic, and the polarity inversion.

Verification
REQ-023 rst_n=0 with W..Z=1000 for 2 cycles -> A..G=0000000; release rst_n -> the next edge gives A..G=1111111.
REQ-024 Sweep 0-9, one value per cycle -> each pattern matches REQ-012 exactly one cycle after it is applied (e.g. 0001 -> BC only, 0111 -> ABC only).
REQ-025 Apply 1010-1111 without the macro -> all segments off; with SEVEN_SEGMENT_HEX_EN -> 1011 gives CDEFG and 1111 gives AEFG.
REQ-026 ACTIVE_LOW_SEG=1, input 0000 -> A..F=0 and G=1; during reset -> all outputs 1.
REQ-027 Change an input between clock edges -> outputs do not change until the next posedge.
REQ-028 Assert rst_n=0 while displaying 8 -> the display blanks at that edge; hold rst_n=0 and change the inputs -> outputs stay blank.
